// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in / serial-out shifter with a valid/ready load
//                handshake, selectable bit order and consumer shift enable.
//                A word is captured together with its shift direction.
//                It is then presented one bit at a time on sout, and each
//                bit advances only when en=1. A one-cycle done pulse
//                follows the final bit.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                din[N-1:0] - parallel word to serialize
//                load_valid - din/dir are presented for loading
//                load_ready - block can accept a word (IDLE)
//                dir        - 1 = MSB first, 0 = LSB first
//                en         - consumer takes the current bit
//                sout       - serial data bit
//                sout_valid - sout carries a word bit
//                done       - one-cycle pulse after the last bit is consumed
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         dir,
    input  logic         en,
    output logic         sout,
    output logic         sout_valid,
    output logic         done
);

    localparam int                 c_CNT_W = $clog2(N);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(N - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [N-1:0]         shreg_q, shreg_d;
    logic [c_CNT_W-1:0]   cnt_q,   cnt_d;
    logic                 dir_q,   dir_d;
    logic                 done_q,  done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // load_ready is high in IDLE, so load_valid alone accepts.
                if (load_valid) begin
                    shreg_d = din;
                    dir_d   = dir;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (en) begin
                    if (cnt_q == c_LAST) begin
                        // Last bit consumed: back to IDLE so a new word can
                        // be accepted during the done cycle.
                        state_d = S_IDLE;
                        shreg_d = '0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        // Shift toward the output end, zero fill.
                        shreg_d = dir_q ? {shreg_q[N-2:0], 1'b0}
                                        : {1'b0, shreg_q[N-1:1]};
                        cnt_d   = cnt_q + c_CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign load_ready = (state_q == S_IDLE);
    assign sout_valid = (state_q == S_SHIFT);
    assign sout       = (state_q == S_SHIFT) ? (dir_q ? shreg_q[N-1] : shreg_q[0])
                                             : 1'b0;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Self-checking bench for piso_serializer (N=4). Expected
//                bits come from the word, the bit order and the bit index.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] din;
    logic         load_valid;
    logic         load_ready;
    logic         dir;
    logic         en;
    logic         sout;
    logic         sout_valid;
    logic         done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    piso_serializer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .dir        (dir),
        .en         (en),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference: bit number idx of a word sent in order d.
    function automatic logic model_bit(input logic [N-1:0] w, input logic d, input int idx);
        int pos;
        pos = d ? (N - 1 - idx) : idx;
        return w[pos];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Loads one word and consumes it. mode: 0 en held 1, 1 en alternating
    // from the accept edge (each bit held two cycles), 2 random en.
    // junk: keep offering a different word with a toggling dir during SHIFT.
    task automatic run_word(input string name, input logic [N-1:0] w, input logic d,
                            input int mode, input bit junk);
        int idx;
        int cyc;
        logic en_v;
        total_cnt++;
        if (load_ready !== 1'b1) $display("FAIL %s load_ready_before: got %b want 1", name, load_ready);
        else pass_cnt++;
        din = w; dir = d; load_valid = 1'b1; en = 1'b1;
        step();
        load_valid = junk; din = junk ? 4'b1111 : din;
        idx = 0; cyc = 0;
        while (idx < N) begin
            if (cyc > 200) begin
                total_cnt++;
                $display("FAIL %s timeout: got %0d bits want %0d", name, idx, N);
                break;
            end
            total_cnt++;
            if (sout_valid !== 1'b1) $display("FAIL %s sout_valid bit%0d: got %b want 1", name, idx, sout_valid);
            else pass_cnt++;
            total_cnt++;
            if (sout !== model_bit(w, d, idx))
                $display("FAIL %s sout bit%0d: got %b want %b", name, idx, sout, model_bit(w, d, idx));
            else pass_cnt++;
            total_cnt++;
            if (load_ready !== 1'b0 || done !== 1'b0)
                $display("FAIL %s ready_done bit%0d: got %b%b want 00", name, idx, load_ready, done);
            else pass_cnt++;
            case (mode)
                0:       en_v = 1'b1;
                1:       en_v = (cyc % 2 == 1);
                default: en_v = 1'($urandom_range(0, 1));
            endcase
            en = en_v;
            if (junk) dir = ~dir;
            step();
            cyc++;
            if (en_v) idx++;
        end
        en = 1'b0; load_valid = 1'b0;
        if (mode < 2) begin
            total_cnt++;
            if (cyc !== (mode == 0 ? N : 2 * N))
                $display("FAIL %s valid_cycles: got %0d want %0d", name, cyc, (mode == 0 ? N : 2 * N));
            else pass_cnt++;
        end
        total_cnt++;
        if ({done, load_ready, sout_valid, sout} !== 4'b1100)
            $display("FAIL %s done_cycle: got %b want 1100", name, {done, load_ready, sout_valid, sout});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({done, load_ready, sout_valid} !== 3'b010)
            $display("FAIL %s after_done: got %b want 010", name, {done, load_ready, sout_valid});
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = '0; load_valid = 1'b0; dir = 1'b0; en = 1'b0;
        step(); step();
        total_cnt++;
        if ({load_ready, sout_valid, sout, done} !== 4'b1000)
            $display("FAIL reset_state: got %b want 1000", {load_ready, sout_valid, sout, done});
        else pass_cnt++;
        // Reset wins over a load offered on the same edge.
        load_valid = 1'b1; din = 4'b1111;
        step();
        total_cnt++;
        if ({load_ready, sout_valid, done} !== 3'b100)
            $display("FAIL reset_over_load: got %b want 100", {load_ready, sout_valid, done});
        else pass_cnt++;
        load_valid = 1'b0; rst = 1'b0;
        step();
        total_cnt++;
        if ({load_ready, sout_valid, sout} !== 3'b100)
            $display("FAIL idle_after_reset: got %b want 100", {load_ready, sout_valid, sout});
        else pass_cnt++;
    endtask

    task automatic test_msb_first();
        run_word("msb_first", 4'b1011, 1'b1, 0, 1'b0);
    endtask

    task automatic test_lsb_first();
        run_word("lsb_first", 4'b1011, 1'b0, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_word("stall", 4'b0110, 1'b1, 1, 1'b0);
    endtask

    task automatic test_load_during_shift();
        run_word("ignore_load", 4'b1001, 1'b1, 0, 1'b1);
        run_word("after_ignore", 4'b1111, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_word();
        din = 4'b1100; dir = 1'b1; load_valid = 1'b1; en = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 2; i++) step();
        total_cnt++;
        if ({sout_valid, sout} !== 2'b10)
            $display("FAIL midword_bit2: got %b want 10", {sout_valid, sout});
        else pass_cnt++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if ({sout, sout_valid, load_ready, done} !== 4'b0010)
            $display("FAIL midword_reset: got %b want 0010", {sout, sout_valid, load_ready, done});
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            step();
            total_cnt++;
            if ({done, sout_valid} !== 2'b00)
                $display("FAIL midword_no_done c%0d: got %b want 00", i, {done, sout_valid});
            else pass_cnt++;
        end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] w [2];
        logic d;
        int pos;
        int wi;
        logic [2:0] exp_v;
        for (int r = 0; r < 3; r++) begin
            if (r == 0) begin
                w[0] = 4'b1010; w[1] = 4'b0101; d = 1'b1;
            end else begin
                w[0] = 4'($urandom); w[1] = 4'($urandom); d = 1'($urandom_range(0, 1));
            end
            din = w[0]; dir = d; load_valid = 1'b1; en = 1'b1;
            step();
            for (int k = 1; k <= 10; k++) begin
                pos = (k - 1) % 5;
                wi  = (k - 1) / 5;
                if (pos < N) exp_v = {1'b1, model_bit(w[wi], d, pos), 1'b0};
                else         exp_v = 3'b001;
                total_cnt++;
                if ({sout_valid, sout, done} !== exp_v)
                    $display("FAIL b2b r%0d c%0d valid_sout_done: got %b want %b",
                             r, k, {sout_valid, sout, done}, exp_v);
                else pass_cnt++;
                if (k == 1) din = w[1];
                if (k == 6) load_valid = 1'b0;
                step();
            end
            en = 1'b0;
            step();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++)
            run_word("random", 4'($urandom), 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_stall();
        test_load_during_shift();
        test_reset_mid_word();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter N, default 4: parallel word width in bits, legal range N >= 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port din, input, N bits: parallel word to serialize.
REQ-005 SHALL have port load_valid, input, 1 bit: din and dir are presented for loading.
REQ-006 SHALL have port load_ready, output, 1 bit: block can accept a word.
REQ-007 SHALL have port dir, input, 1 bit: shift order; 1 = MSB first (shift left), 0 = LSB first (shift right).
REQ-008 SHALL have port en, input, 1 bit: shift enable; the consumer takes the current bit when en=1.
REQ-009 SHALL have port sout, output, 1 bit: serial data bit.
REQ-010 SHALL have port sout_valid, output, 1 bit: sout carries a word bit.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the final bit of a word is consumed.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and SHIFT, plus an N-bit shift register and a bit counter of width clog2(N).
REQ-013 In IDLE: load_ready=1, sout_valid=0, sout=0; en is ignored.
REQ-014 Load is accepted on a rising edge where load_valid=1 and load_ready=1: din and dir are captured, counter=0, FSM moves to SHIFT.
REQ-015 dir and din SHALL be sampled only at accept; changes during SHIFT have no effect on the word in flight.
REQ-016 In SHIFT: load_ready=0 and sout_valid=1; sout = register MSB if captured dir=1, else register LSB.
REQ-017 First bit is on sout in the cycle immediately after accept (latency 1).
REQ-018 On an edge in SHIFT with en=1 and counter<N-1: shift one position in the captured direction with 0 fill, counter increments.
REQ-019 On an edge in SHIFT with en=1 and counter=N-1: FSM returns to IDLE, register clears, done=1 for exactly the next cycle.
REQ-020 On an edge in SHIFT with en=0: register, counter and sout are held (stall of any length).
REQ-021 load_valid during SHIFT SHALL be ignored; no word is lost or overwritten.
REQ-022 In the done cycle the FSM is in IDLE with load_ready=1, so a back-to-back load is accepted in that cycle; the next word's first bit appears the following cycle.
REQ-023 A word always yields exactly N valid bits, each consumed exactly once.

Reset
REQ-024 With rst=1 at a rising edge, the next state SHALL be IDLE with register=0, counter=0, sout=0, sout_valid=0, done=0 and load_ready=1.
REQ-025 rst SHALL take priority over load and shift, including mid-word; the partial word is discarded and no done pulse is issued.
REQ-026 Outputs before the first reset edge are unspecified; the bench asserts rst for at least one edge first.

Verification (N=4)
REQ-027 din=4'b1011, dir=1, en held 1 -> sout 1,0,1,1 on four consecutive cycles with sout_valid=1, then done=1 and load_ready=1 for one cycle.
REQ-028 din=4'b1011, dir=0, en held 1 -> sout 1,1,0,1, then done pulse.
REQ-029 din=4'b0110, dir=1, en alternating 1,0 starting 1 -> bits 0,1,1,0 each held two cycles, sout_valid=1 for 8 cycles, then done.
REQ-030 Word 4'b1001 in SHIFT while load_valid=1 with din=4'b1111 and dir toggling -> output remains 1,0,0,1; 4'b1111 is accepted only when load_ready=1.
REQ-031 rst=1 after two bits of 4'b1100 -> next cycle sout=0, sout_valid=0, load_ready=1, done=0 and no later done pulse.
REQ-032 load_valid held 1 with 4'b1010 then 4'b0101, dir=1, en=1 -> sout 1,0,1,0,0,1,0,1 with one non-valid cycle (the done cycle) between words.
